// File: rtl/onn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : onn_pkg
//  Description : Shared constants, types and helpers for the 3x5 oscillatory
//                neural network (array top, neurons, coupling synapses).
//  Revision    : 1.0 - initial release
// ============================================================================
package onn_pkg;

    localparam int ARRAY_ROWS  = 3;
    localparam int ARRAY_COLS  = 5;
    localparam int N_NEURONS   = ARRAY_ROWS * ARRAY_COLS;
    localparam int W_BITS      = 4;
    localparam int W_ADDR_BITS = 4;

    // Register stages between osc_in and a sum_out that reflects real inputs.
    localparam int FILL_DEPTH  = 2;

    typedef logic signed [W_BITS-1:0] weight_t;

    // Accumulator width for n_in signed terms of w_bits each, with one extra
    // bit so that negating the most negative weight cannot overflow.
    function automatic int sum_bits(input int n_in, input int w_bits);
        return w_bits + $clog2(n_in) + 1;
    endfunction

    localparam int SUM_BITS = sum_bits(N_NEURONS, W_BITS);

    // Row-major neuron numbering used for osc bit positions and weight addresses.
    function automatic int neuron_index(input int row, input int col);
        return row * ARRAY_COLS + col;
    endfunction

endpackage : onn_pkg
`default_nettype wire

// File: rtl/signed_adder_tree.sv
`default_nettype none
// ============================================================================
//  Module      : signed_adder_tree
//  Description : Combinational sum of N_IN sign-extended weights, each added
//                when its select bit is 1 and subtracted when it is 0.
//  Ports       : i_sel     [N_IN]          per-term sign select (1 = +w)
//                i_weights [N_IN*W_BITS]   packed signed weights, term i at
//                                          bits [i*W_BITS +: W_BITS]
//                o_sum     [SUM_BITS]      signed result
//  Revision    : 1.0 - initial release
// ============================================================================
module signed_adder_tree #(
    parameter int N_IN     = 15,
    parameter int W_BITS   = 4,
    parameter int SUM_BITS = 9
) (
    input  logic [N_IN-1:0]               i_sel,
    input  logic [N_IN*W_BITS-1:0]        i_weights,
    output logic signed [SUM_BITS-1:0]    o_sum
);

    logic signed [SUM_BITS-1:0] w_terms [N_IN];
    logic signed [SUM_BITS-1:0] w_acc;

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_term
            logic signed [W_BITS-1:0]   w_wt;
            logic signed [SUM_BITS-1:0] w_ext;

            assign w_wt  = i_weights[gi*W_BITS +: W_BITS];
            assign w_ext = {{(SUM_BITS-W_BITS){w_wt[W_BITS-1]}}, w_wt};
            // -(-8) = +8 is representable thanks to the extra accumulator bit.
            assign w_terms[gi] = i_sel[gi] ? w_ext : -w_ext;
        end
    endgenerate

    // Written as a chain; synthesis is free to rebalance it into a tree.
    always_comb begin
        w_acc = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_acc = w_acc + w_terms[i];
        end
    end

    assign o_sum = w_acc;

endmodule : signed_adder_tree
`default_nettype wire

// File: rtl/coupling_synapse.sv
`default_nettype none
// ============================================================================
//  Module      : coupling_synapse
//  Description : Forms one neuron's coupling input 'nin' from the oscillator
//                outputs of all neurons: registered input, registered signed
//                weighted sum, then sign-to-bit with hold on zero or freeze.
//  Ports       : sclk, re                  clock / sync active-high reset
//                osc_in    [N_IN]          coupled oscillator bits
//                w_wr_en, w_wr_addr[4],
//                w_wr_data [W_BITS]        weight register-file write port
//                freeze                    hold nin
//                nin                       coupling output
//                sum_out   [SUM_BITS]      registered weighted sum
//                sum_valid                 pipeline filled since reset
//  Revision    : 1.0 - initial release
// ============================================================================
module coupling_synapse #(
    parameter int N_IN     = onn_pkg::N_NEURONS,
    parameter int W_BITS   = onn_pkg::W_BITS,
    parameter int SUM_BITS = onn_pkg::sum_bits(N_IN, W_BITS)
) (
    input  logic                        sclk,
    input  logic                        re,
    input  logic [N_IN-1:0]             osc_in,
    input  logic                        w_wr_en,
    input  logic [3:0]                  w_wr_addr,
    input  logic [W_BITS-1:0]           w_wr_data,
    input  logic                        freeze,
    output logic                        nin,
    output logic signed [SUM_BITS-1:0]  sum_out,
    output logic                        sum_valid
);

    import onn_pkg::*;

    localparam logic [1:0] c_fill_full = 2'(FILL_DEPTH);

    logic signed [W_BITS-1:0]   weights_q [N_IN];
    logic signed [W_BITS-1:0]   weights_d [N_IN];
    logic [N_IN-1:0]            osc_q,  osc_d;
    logic signed [SUM_BITS-1:0] sum_q,  sum_d;
    logic                       nin_q,  nin_d;
    logic [1:0]                 fill_q, fill_d;

    logic [N_IN*W_BITS-1:0]     w_weights_flat;
    logic signed [SUM_BITS-1:0] w_tree_sum;

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_flat
            assign w_weights_flat[gi*W_BITS +: W_BITS] = weights_q[gi];
        end
    endgenerate

    signed_adder_tree #(
        .N_IN     (N_IN),
        .W_BITS   (W_BITS),
        .SUM_BITS (SUM_BITS)
    ) u_tree (
        .i_sel     (osc_q),
        .i_weights (w_weights_flat),
        .o_sum     (w_tree_sum)
    );

    always_comb begin
        weights_d = weights_q;
        // Out-of-range addresses fall through and leave the file untouched.
        if (w_wr_en && (int'(w_wr_addr) < N_IN)) begin
            weights_d[w_wr_addr] = w_wr_data;
        end

        osc_d = osc_in;
        sum_d = w_tree_sum;

        // A zero sum is a tie between the coupled groups: keep the last decision.
        nin_d = nin_q;
        if (!freeze) begin
            if (sum_q > 0) begin
                nin_d = 1'b1;
            end else if (sum_q < 0) begin
                nin_d = 1'b0;
            end
        end

        fill_d = (fill_q == c_fill_full) ? fill_q : fill_q + 2'd1;
    end

    always_ff @(posedge sclk) begin
        if (re) begin
            for (int i = 0; i < N_IN; i++) begin
                weights_q[i] <= '0;
            end
            osc_q  <= '0;
            sum_q  <= '0;
            nin_q  <= 1'b0;
            fill_q <= 2'd0;
        end else begin
            weights_q <= weights_d;
            osc_q     <= osc_d;
            sum_q     <= sum_d;
            nin_q     <= nin_d;
            fill_q    <= fill_d;
        end
    end

    assign nin       = nin_q;
    assign sum_out   = sum_q;
    assign sum_valid = (fill_q == c_fill_full);

endmodule : coupling_synapse
`default_nettype wire

// File: tb/tb_coupling_synapse.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coupling_synapse
//  Description : Self-checking bench for coupling_synapse. Stimulus pushes the
//                behaviourally predicted outputs into a queue; a monitor pops
//                and compares once per cycle. Directed scenarios also check
//                absolute values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_coupling_synapse;

    import onn_pkg::*;

    localparam int N  = N_NEURONS;
    localparam int SB = SUM_BITS;

    logic                   clk = 1'b0;
    logic                   re;
    logic [N-1:0]           osc_in;
    logic                   w_wr_en;
    logic [3:0]             w_wr_addr;
    logic [W_BITS-1:0]      w_wr_data;
    logic                   freeze;
    logic                   nin;
    logic signed [SB-1:0]   sum_out;
    logic                   sum_valid;

    always #5 clk = ~clk;

    coupling_synapse dut (
        .sclk      (clk),
        .re        (re),
        .osc_in    (osc_in),
        .w_wr_en   (w_wr_en),
        .w_wr_addr (w_wr_addr),
        .w_wr_data (w_wr_data),
        .freeze    (freeze),
        .nin       (nin),
        .sum_out   (sum_out),
        .sum_valid (sum_valid)
    );

    typedef struct {
        int   sum;
        logic nin;
        logic valid;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: state as seen just after the most recent edge.
    int           m_w [N];
    logic [N-1:0] m_osc;
    int           m_sum;
    logic         m_nin;
    int           m_cycles;

    function automatic int weighted_sum(input logic [N-1:0] osc);
        int s = 0;
        for (int i = 0; i < N; i++) s += osc[i] ? m_w[i] : -m_w[i];
        return s;
    endfunction

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, predict the outputs after the coming edge,
    // then advance to just after that edge.
    task automatic step(input logic r, input logic [N-1:0] osc, input logic we,
                        input logic [3:0] wa, input logic [W_BITS-1:0] wd,
                        input logic frz);
        exp_t e;
        logic nxt_nin;
        re = r; osc_in = osc; w_wr_en = we; w_wr_addr = wa; w_wr_data = wd; freeze = frz;
        if (r) begin
            for (int i = 0; i < N; i++) m_w[i] = 0;
            m_osc = '0; m_sum = 0; m_nin = 1'b0; m_cycles = 0;
        end else begin
            nxt_nin = m_nin;
            if (!frz && m_sum > 0) nxt_nin = 1'b1;
            if (!frz && m_sum < 0) nxt_nin = 1'b0;
            m_nin = nxt_nin;
            m_sum = weighted_sum(m_osc);
            m_osc = osc;
            if (we && int'(wa) < N) m_w[wa] = int'($signed(wd));
            m_cycles++;
        end
        e.sum   = m_sum;
        e.nin   = m_nin;
        e.valid = (m_cycles >= 2);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [N-1:0] osc, input logic frz, input int n);
        for (int i = 0; i < n; i++) step(1'b0, osc, 1'b0, 4'd0, '0, frz);
    endtask

    task automatic wr(input logic [3:0] wa, input logic [W_BITS-1:0] wd, input logic [N-1:0] osc);
        step(1'b0, osc, 1'b1, wa, wd, 1'b0);
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (int'(sum_out) != e.sum) begin
                    errors++;
                    $display("FAIL sb_sum: got %0d expected %0d at %0t", sum_out, e.sum, $time);
                end
                checks++;
                if (nin !== e.nin) begin
                    errors++;
                    $display("FAIL sb_nin: got %b expected %b at %0t", nin, e.nin, $time);
                end
                checks++;
                if (sum_valid !== e.valid) begin
                    errors++;
                    $display("FAIL sb_valid: got %b expected %b at %0t", sum_valid, e.valid, $time);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [N-1:0] all1;
        all1 = '1;

        // Reset with random traffic: reset must dominate writes and freeze.
        for (int i = 0; i < 2; i++)
            step(1'b1, N'($urandom()), 1'b1, 4'($urandom()), W_BITS'($urandom()), 1'($urandom()));
        check_val("reset_nin", int'(nin), 0);
        check_val("reset_sum", int'(sum_out), 0);
        check_val("reset_valid", int'(sum_valid), 0);
        hold(N'($urandom()), 1'b0, 1);
        check_val("valid_edge1", int'(sum_valid), 0);
        hold(N'($urandom()), 1'b0, 1);
        check_val("valid_edge2", int'(sum_valid), 1);
        check_val("zero_w_sum", int'(sum_out), 0);

        // Single coupling through neuron 3.
        wr(4'd3, 4'd5, '0);
        hold(N'(1 << 3), 1'b0, 4);
        check_val("single_pos_sum", int'(sum_out), 5);
        check_val("single_pos_nin", int'(nin), 1);
        hold('0, 1'b0, 2);
        check_val("single_neg_sum", int'(sum_out), -5);
        check_val("single_nin_edge2", int'(nin), 1);
        hold('0, 1'b0, 1);
        check_val("single_nin_edge3", int'(nin), 0);

        // Tie hold, from nin=0 and from nin=1.
        wr(4'd3, 4'd0, '0);
        wr(4'd0, 4'd2, '0);
        wr(4'd1, 4'd2, '0);
        hold(N'(2'b01), 1'b0, 4);
        check_val("tie_sum0", int'(sum_out), 0);
        check_val("tie_hold0", int'(nin), 0);
        hold(N'(2'b11), 1'b0, 4);
        check_val("tie_pre1", int'(nin), 1);
        hold(N'(2'b01), 1'b0, 4);
        check_val("tie_sum1", int'(sum_out), 0);
        check_val("tie_hold1", int'(nin), 1);

        // Extremes: every weight at -8.
        for (int i = 0; i < N; i++) wr(4'(i), 4'b1000, all1);
        hold(all1, 1'b0, 4);
        check_val("ext_neg_sum", int'(sum_out), -120);
        check_val("ext_neg_nin", int'(nin), 0);
        hold('0, 1'b0, 4);
        check_val("ext_pos_sum", int'(sum_out), 120);
        check_val("ext_pos_nin", int'(nin), 1);

        // Out-of-range write, then an in-range write while running.
        wr(4'd15, 4'd7, '0);
        hold('0, 1'b0, 3);
        check_val("oor_write_sum", int'(sum_out), 120);
        wr(4'd2, 4'd7, '0);
        check_val("wr_old_weight", int'(sum_out), 120);
        hold('0, 1'b0, 1);
        check_val("wr_new_weight", int'(sum_out), 105);

        // Freeze while the sum flips sign.
        hold(all1, 1'b1, 4);
        check_val("frz_sum", int'(sum_out), -105);
        check_val("frz_nin", int'(nin), 1);
        hold(all1, 1'b0, 1);
        check_val("frz_release_nin", int'(nin), 0);

        // Mid-operation reset clears weights.
        step(1'b1, all1, 1'b0, 4'd0, '0, 1'b0);
        hold(all1, 1'b0, 3);
        check_val("rst_clears_w", int'(sum_out), 0);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 99) == 0),
                 N'($urandom()),
                 ($urandom_range(0, 1) == 1),
                 4'($urandom_range(0, 15)),
                 W_BITS'($urandom()),
                 ($urandom_range(0, 7) == 0));
        end

        @(negedge clk);
        #1;
        check_val("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_coupling_synapse
`default_nettype wire
